// File: rtl/fides_sr_colfeed_pkg.sv
// Shared definitions for the Fides-192 threshold ShiftRows / column feed stage:
// cell geometry, share count, ShiftRows row offsets and the feed FSM encoding.
package fides_sr_colfeed_pkg;

  localparam int CELL_W   = 6;
  localparam int N_SHARES = 3;
  localparam int N_ROWS   = 4;
  localparam int N_COLS   = 4;

  // Row r of the state rotates left by SR_OFFSET[r] cells.
  localparam int SR_OFFSET [N_ROWS] = '{0, 1, 2, 3};

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Linear cell index of (row, column) inside one share, column-major.
  function automatic int idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/fides_shiftrows_share.sv
// ShiftRows on a single 16-cell share: pure wiring, out(r,c) = in(r,(c+r) mod 4).
module fides_shiftrows_share
  import fides_sr_colfeed_pkg::*;
#(
  parameter int W = CELL_W
) (
  input  logic [16*W-1:0] cells_in,
  output logic [16*W-1:0] cells_out
);

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar c = 0; c < N_COLS; c++) begin : g_col
      assign cells_out[idx(r, c)*W +: W] =
        cells_in[idx(r, (c + SR_OFFSET[r]) % N_COLS)*W +: W];
    end
  end

endmodule

// File: rtl/fides_sr_colfeed.sv
// Captures one shared 96-bit Fides state ShiftRows-permuted and feeds it to the
// per-share MixColumns one column per cycle, all shares side by side.
module fides_sr_colfeed
  import fides_sr_colfeed_pkg::*;
#(
  parameter int W      = CELL_W,
  parameter int SHARES = N_SHARES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SHARES*16*W-1:0] in_state,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic [SHARES*4*W-1:0] col_data,
  output logic [1:0]            col_idx,
  output logic                  col_last
);

  localparam int SW = 16 * W;
  localparam int CW = 4 * W;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and ready/valid here come only from
  // the FSM state, never from the opposite side's signal.
  state_t                 state;
  logic [1:0]             col_idx_q;
  logic [SHARES*SW-1:0]   buf_q;
  logic [SHARES*SW-1:0]   sr_state;
  logic                   in_fire;
  logic                   col_fire;

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    fides_shiftrows_share #(.W(W)) u_sr (
      .cells_in  (in_state[s*SW +: SW]),
      .cells_out (sr_state[s*SW +: SW])
    );
  end

  assign in_ready  = (state == IDLE);
  assign col_valid = (state == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign col_fire  = col_valid && col_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col_idx_q <= 2'd0;
      buf_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            buf_q     <= sr_state;
            col_idx_q <= 2'd0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (col_fire) begin
            col_idx_q <= col_idx_q + 2'd1;
            if (col_idx_q == 2'd3) state <= IDLE;
          end
        end
      endcase
    end
  end

  // Only the column mux sits between the buffer registers and the outputs.
  always_comb begin
    col_data = '0;
    for (int s = 0; s < SHARES; s++) begin
      col_data[s*CW +: CW] = buf_q[s*SW + int'(col_idx_q)*CW +: CW];
    end
  end

  assign col_idx  = col_idx_q;
  assign col_last = col_valid && (col_idx_q == 2'd3);

endmodule

// File: tb/tb_fides_sr_colfeed.sv
// Scoreboard bench for fides_sr_colfeed: drivers push expected columns at
// capture, a negedge monitor pops and compares every column transfer.
module tb_fides_sr_colfeed;

  localparam int W      = 6;
  localparam int SHARES = 3;
  localparam int SW     = 16 * W;
  localparam int STW    = SHARES * SW;
  localparam int DW     = SHARES * 4 * W;
  localparam int EW     = DW + 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [STW-1:0] in_state;
  logic           col_valid;
  logic           col_ready;
  logic [DW-1:0]  col_data;
  logic [1:0]     col_idx;
  logic           col_last;

  logic           rand_ready;
  logic           ready_ctl;
  logic           rnd_bit;

  int checks = 0;
  int errors = 0;
  int last_wait;

  logic [EW-1:0] exp_q[$];

  fides_sr_colfeed #(.W(W), .SHARES(SHARES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .col_idx   (col_idx),
    .col_last  (col_last)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  assign col_ready = rand_ready ? rnd_bit : ready_ctl;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model_col(input logic [STW-1:0] st, input int c);
    logic [DW-1:0] res;
    res = '0;
    for (int s = 0; s < SHARES; s++)
      for (int r = 0; r < 4; r++)
        res[s*4*W + r*W +: W] = st[s*SW + (4*((c + r) % 4) + r)*W +: W];
    return res;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_model(input logic [STW-1:0] st);
    for (int c = 0; c < 4; c++)
      exp_q.push_back({(c == 3), 2'(c), model_col(st, c)});
  endtask

  // ---------------- driver tasks ----------------
  // Offers st until captured; returns at the negedge where column 0 is shown.
  task automatic send_state(input logic [STW-1:0] st, input bit push);
    bit got;
    int waited;
    got = 0;
    waited = 0;
    in_state = st;
    in_valid = 1'b1;
    while (!got && waited < 64) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else waited++;
    end
    last_wait = waited;
    if (!got) begin
      check("capture_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (push) push_model(st);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("first_col", {col_valid, col_idx}, {1'b1, 2'd0});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && col_valid && col_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_col", {col_last, col_idx, col_data}, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("col", {col_last, col_idx, col_data}, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [STW-1:0] st_a, st_b, st_c, st_d, st_p;
    logic [SW-1:0]  s0, s1, s2, mask;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_state   = '0;
    ready_ctl  = 1'b1;
    rand_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_col_valid", col_valid, 0);
    check("rst_col_idx", col_idx, 0);
    check("rst_col_data", col_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Permutation: share0 cell i holds i, other shares zero; hand-computed columns.
    st_a = '0;
    for (int i = 0; i < 16; i++) st_a[i*W +: W] = 6'(i);
    exp_q.push_back({1'b0, 2'd0, 48'd0, 6'd15, 6'd10, 6'd5,  6'd0});
    exp_q.push_back({1'b0, 2'd1, 48'd0, 6'd3,  6'd14, 6'd9,  6'd4});
    exp_q.push_back({1'b0, 2'd2, 48'd0, 6'd7,  6'd2,  6'd13, 6'd8});
    exp_q.push_back({1'b1, 2'd3, 48'd0, 6'd11, 6'd6,  6'd1,  6'd12});
    send_state(st_a, 0);
    wait_drain();
    @(posedge clk);
    #1;

    // Backpressure at column 1 for three cycles.
    for (int s = 0; s < SHARES; s++)
      for (int i = 0; i < 16; i++) st_p[s*SW + i*W +: W] = 6'(16*s + i + 1);
    send_state(st_p, 1);
    @(posedge clk);
    #1 ready_ctl = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold", {col_valid, col_last, col_idx, col_data},
            {1'b1, 1'b0, 2'd1, model_col(st_p, 1)});
    end
    @(posedge clk);
    #1 ready_ctl = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_idx", {col_valid, col_idx}, {1'b1, 2'd2});
    wait_drain();
    @(posedge clk);
    #1;

    // Back-to-back: second state offered while the first is still emitting.
    st_a = {32'hdead_beef, 64'h0123_4567_89ab_cdef,
            32'h1357_9bdf, 64'h2468_ace0_1122_3344,
            32'h5566_7788, 64'h99aa_bbcc_ddee_ff00};
    st_b = ~st_a;
    send_state(st_a, 1);
    send_state(st_b, 1);
    check("b2b_wait_cycles", last_wait, 3);
    wait_drain();
    repeat (4) @(negedge clk);
    check("b2b_idle_ready", {in_ready, col_valid}, {1'b1, 1'b0});

    // Reset in the middle of emission, after column 1 has transferred.
    @(posedge clk);
    #1;
    st_c = {3{96'hfedc_ba98_7654_3210_0f1e_2d3c}};
    st_d = {3{96'h1111_2222_3333_4444_5555_6666}} ^ {STW{1'b1}};
    send_state(st_c, 1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_state = st_a;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_col_valid", col_valid, 0);
    check("mid_rst_col_idx", col_idx, 0);
    check("mid_rst_col_last", col_last, 0);
    check("mid_rst_col_data", col_data, 0);
    check("mid_rst_pending", exp_q.size(), 2);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {in_ready, col_valid}, {1'b1, 1'b0});
    @(posedge clk);
    #1;
    send_state(st_d, 1);
    wait_drain();
    @(posedge clk);
    #1;

    // Share independence: share1 = share0 ^ mask, random downstream stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      s0   = {$urandom(), $urandom(), $urandom()};
      mask = {$urandom(), $urandom(), $urandom()};
      s2   = {$urandom(), $urandom(), $urandom()};
      s1   = s0 ^ mask;
      send_state({s2, s1, s0}, 1);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fides_sr_colfeed.md
# fides_sr_colfeed

Column-serial ShiftRows and feed stage for the three-share threshold Fides-192 datapath, placed directly upstream of the per-share MixColumns instances. It accepts one full shared 96-bit state, applies ShiftRows to every share on capture and buffers the result. It then presents the state one column per cycle, for all shares in parallel, to the MixColumns inputs a1..a4 under a valid/ready handshake. Shares are never combined; every share takes an identical, independent path.

## Interface
Parameters:
- W, 6, cell width in bits.
- SHARES, 3, number of TI shares.

Ports:
- clk  in  1  clock. One clock domain, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  a shared state is offered on in_state.
- in_ready  out  1  the block can capture a state.
- in_state  in  SHARES*16*W  share s occupies bits [s*16*W +: 16*W]. Cell (r,c) of a share is at [(4*c+r)*W +: W].
- col_valid  out  1  the column on col_data is valid.
- col_ready  in  1  downstream consumes the column.
- col_data  out  SHARES*4*W  per share s, [s*4*W +: 4*W] = {row3,row2,row1,row0}. Row0 drives a1 and row3 drives a4 of that share's MixColumns.
- col_idx  out  2  index of the column presented, 0..3.
- col_last  out  1  high while col_idx==3.

## Operation
- FSM states:
  - IDLE: in_ready=1, col_valid=0.
  - EMIT: in_ready=0, col_valid=1.
- IDLE → EMIT on in_valid&&in_ready.
  - On that edge every share is written to the buffer ShiftRows-permuted: buf(r,c) = in(r,(c+r) mod 4), for r,c in 0..3.
  - The column counter is cleared to 0.
- In EMIT, col_data shows buf column col_idx of every share.
  - col_valid&&col_ready advances col_idx on the same edge.
  - If col_valid is high and col_ready is low, col_data, col_idx and col_last are held stable with no change.
- The transfer of column 3 returns the FSM to IDLE. col_idx wraps to 0.
- in_valid is ignored in EMIT. No capture happens, and the upstream must hold its offer.
- There is no pipelining of states: a new state is captured at the earliest on the cycle after the column-3 transfer.
- ShiftRows is pure wiring, with no XOR and no mixing across shares.
- After the buffer is loaded, col_data comes straight from registers. Only the col_idx mux sits between them, which limits glitch propagation across shares.
- Reset (rst_n low, at any time including mid-EMIT):
  - FSM goes to IDLE, col_idx=0, buffer zeroed.
  - Outputs: in_ready=1, col_valid=0, col_last=0, col_data=0.
  - A partially emitted state is discarded. The first in_valid after rst_n deasserts is a fresh capture.

## Timing
- Capture edge to col_valid=1 with col_idx=0: 1 cycle.
- With col_ready tied high:
  - Columns 0..3 appear on 4 consecutive cycles.
  - in_ready rises the cycle after column 3.
  - Throughput is one state per 5 cycles.
- in_ready depends only on the FSM state, never combinationally on in_valid.
- col_valid depends only on the FSM state, never combinationally on col_ready.
- rst_n deasserts asynchronously. A synchronised deassertion is the system's responsibility.

## Structure
- The shared fides package holds:
  - W
  - SHARES
  - the cell-index function idx(r,c)=4*c+r
  - the ShiftRows offset table {0,1,2,3}
  - the FSM state enum (IDLE, EMIT)
- One sub-module, fides_shiftrows_share: a combinational per-share 16-cell permutation, instantiated SHARES times in a generate loop.
- The FSM, column counter and buffer stay in the top module.

## Test plan
- Reset values: assert rst_n=0 mid-sim with arbitrary inputs.
  - Required: in_ready=1, col_valid=0, col_idx=0, col_data=0, asynchronously and without waiting for a clock edge.
- Permutation: share 0 cell (r,c) = 4*c+r, shares 1 and 2 = 0, col_ready=1.
  - Share 0 columns in order: {15,10,5,0}, {3,14,9,4}, {7,2,13,8}, {11,6,1,12} (as {row3..row0}).
  - Shares 1 and 2 = 0. col_last is high only on the 4th column.
- Backpressure:
  - Stimulus: col_ready=0 for 3 cycles at col_idx=1.
  - Required: col_data and col_idx stay constant. Column 2 follows the cycle after col_ready=1.
- Back-to-back states with in_valid held high:
  - Stimulus: second state offered during EMIT.
  - Required: in_ready=0 until the column-3 transfer. The second state is captured exactly once, and its column 0 appears 1 cycle later.
- Reset mid-operation:
  - Stimulus: rst_n pulsed low after column 1 transfers.
  - Required: no further columns. The next capture starts at col_idx=0 with the new data only.
- Share independence:
  - Stimulus: random states where share 1 = share 0 XOR mask.
  - Required: every output column of share 1 = share 0 XOR the same ShiftRows-permuted mask, checked against a reference model over 1000 states.
